// File: rtl/ext_mem_model.sv
// ext_mem_model: external memory emulator with wait states,
// a write-protect window, access counters and sticky error flags.
module ext_mem_model #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int READ_WAIT  = 0,
  parameter int WRITE_WAIT = 0,
  parameter int WP_EN      = 0,
  parameter int WP_BASE    = 0,
  parameter int WP_LIMIT   = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_oe,
  input  logic              bus_we,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_ready,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic              err_collision,
  output logic              err_wp,
  output logic              err_abort
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [3:0] RW_INIT =
    (READ_WAIT > 0) ? 4'(READ_WAIT - 1) : 4'd0;
  localparam logic [3:0] WW_INIT =
    (WRITE_WAIT > 0) ? 4'(WRITE_WAIT - 1) : 4'd0;
  localparam bit WP_ON = (WP_EN != 0) && (WP_LIMIT >= WP_BASE);
  localparam logic [ADDR_W-1:0] WP_B = ADDR_W'(WP_BASE);
  localparam logic [ADDR_W-1:0] WP_SPAN = ADDR_W'(WP_LIMIT - WP_BASE);

  typedef enum logic [1:0] {IDLE, RWAIT, WWAIT} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  rd_cnt_q, wr_cnt_q;
  logic              err_col_q, err_wp_q, err_abort_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              rd_done, wr_done, abort;
  logic              rd_ok, wr_ok, wp_hit, load_hit, wr_fire;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] wr_data, rd_val;

  // Next-state logic: request decode, wait countdown and abort detection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_done = 1'b0;
    wr_done = 1'b0;
    abort   = 1'b0;
    rd_addr = bus_addr;
    wr_addr = bus_addr;
    wr_data = bus_wdata;
    unique case (state_q)
      IDLE: begin
        if (bus_we) begin
          if (WRITE_WAIT == 0) begin
            wr_done = 1'b1;
          end else begin
            state_d = WWAIT;
            cnt_d   = WW_INIT;
            addr_d  = bus_addr;
            wdata_d = bus_wdata;
          end
        end else if (bus_oe) begin
          if (READ_WAIT == 0) begin
            rd_done = 1'b1;
          end else begin
            state_d = RWAIT;
            cnt_d   = RW_INIT;
            addr_d  = bus_addr;
          end
        end
      end
      RWAIT: begin
        rd_addr = addr_q;
        if (!bus_oe || bus_addr != addr_q) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          rd_done = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WWAIT: begin
        wr_addr = addr_q;
        wr_data = wdata_q;
        if (!bus_we || bus_addr != addr_q) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          wr_done = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion qualifiers; held-in-reset cycles never complete
  always_comb begin
    rd_ok    = rd_done & rst_n;
    wr_ok    = wr_done & rst_n;
    wp_hit   = WP_ON && ((wr_addr - WP_B) <= WP_SPAN);
    load_hit = load_en && (load_addr == wr_addr);
    wr_fire  = wr_ok && !wp_hit && !load_hit;
    rd_val   = mem_q[rd_addr];
  end

  assign bus_ready     = rd_ok | wr_ok;
  assign bus_rdata     = rd_ok ? rd_val : rdata_q;
  assign dbg_data      = mem_q[dbg_addr];
  assign rd_count      = rd_cnt_q;
  assign wr_count      = wr_cnt_q;
  assign err_collision = err_col_q;
  assign err_wp        = err_wp_q;
  assign err_abort     = err_abort_q;

  // Storage array: bench preload and CPU commits, never cleared
  always_ff @(posedge clk) begin
    if (load_en) mem_q[load_addr] <= load_data;
    if (wr_fire) mem_q[wr_addr] <= wr_data;
  end

  // Control state, read-data hold, saturating counters, sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      err_col_q   <= 1'b0;
      err_wp_q    <= 1'b0;
      err_abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (rd_ok) rdata_q <= rd_val;
      if (rd_ok && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (wr_fire && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 1'b1;
      if (bus_oe && bus_we) err_col_q <= 1'b1;
      if (wr_ok && wp_hit) err_wp_q <= 1'b1;
      if (abort || (wr_ok && !wp_hit && load_hit)) err_abort_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ext_mem_model.sv
// tb_ext_mem_model: directed bench over four parameterisations
// of ext_mem_model with a read-data scoreboard queue.
module tb_ext_mem_model;

  localparam int N = 4;
  localparam int RW [N] = '{0, 2, 0, 3};
  localparam int WW [N] = '{0, 1, 0, 0};
  localparam int WE [N] = '{0, 0, 1, 0};
  localparam int WL [N] = '{0, 0, 15, 0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0]  a  [N];
  logic        oe [N];
  logic        we [N];
  logic [7:0]  wd [N];
  logic [7:0]  rd [N];
  logic        rdy[N];
  logic        le [N];
  logic [4:0]  la [N];
  logic [7:0]  ld [N];
  logic [4:0]  da [N];
  logic [7:0]  dd [N];
  logic [15:0] rc [N];
  logic [15:0] wc [N];
  logic        ec [N];
  logic        ew [N];
  logic        ea [N];

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    ext_mem_model #(
      .READ_WAIT (RW[g]),
      .WRITE_WAIT(WW[g]),
      .WP_EN     (WE[g]),
      .WP_BASE   (0),
      .WP_LIMIT  (WL[g])
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus_addr     (a[g]),
      .bus_oe       (oe[g]),
      .bus_we       (we[g]),
      .bus_wdata    (wd[g]),
      .bus_rdata    (rd[g]),
      .bus_ready    (rdy[g]),
      .load_en      (le[g]),
      .load_addr    (la[g]),
      .load_data    (ld[g]),
      .dbg_addr     (da[g]),
      .dbg_data     (dd[g]),
      .rd_count     (rc[g]),
      .wr_count     (wc[g]),
      .err_collision(ec[g]),
      .err_wp       (ew[g]),
      .err_abort    (ea[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input logic [4:0] ad,
                      input logic [7:0] d);
    le[k] = 1'b1;
    la[k] = ad;
    ld[k] = d;
    tick();
    le[k] = 1'b0;
  endtask

  task automatic peek(input int k, input logic [4:0] ad,
                      input logic [7:0] e, input string tag);
    da[k] = ad;
    #1;
    chk(tag, dd[k], e);
  endtask

  task automatic await(input int k, input int lat, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, lat);
  endtask

  task automatic rd_pop(input int k, input string tag);
    logic [7:0] e;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else e = 'x;
    chk(tag, rd[k], e);
  endtask

  task automatic read(input int k, input logic [4:0] ad,
                      input logic [7:0] e, input int lat,
                      input string tag);
    exp_q.push_back(e);
    a[k]  = ad;
    oe[k] = 1'b1;
    await(k, lat, {tag, "_lat"});
    rd_pop(k, {tag, "_data"});
    tick();
    oe[k] = 1'b0;
  endtask

  task automatic write(input int k, input logic [4:0] ad,
                       input logic [7:0] d, input int lat,
                       input string tag);
    a[k]  = ad;
    wd[k] = d;
    we[k] = 1'b1;
    await(k, lat, {tag, "_lat"});
    tick();
    we[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      a[k] = '0; oe[k] = 1'b0; we[k] = 1'b0; wd[k] = '0;
      le[k] = 1'b0; la[k] = '0; ld[k] = '0; da[k] = '0;
    end
    #12;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_rdy%0d", k), rdy[k], 1'b0);
      chk($sformatf("rst_rdata%0d", k), rd[k], 8'h00);
      chk($sformatf("rst_rc%0d", k), rc[k], 16'h0);
      chk($sformatf("rst_wc%0d", k), wc[k], 16'h0);
      chk($sformatf("rst_err%0d", k), {ec[k], ew[k], ea[k]}, 3'b000);
    end
    rst_n = 1'b1;
    tick();

    load(0, 5'd3, 8'hA5);
    read(0, 5'd3, 8'hA5, 0, "t1_rd3");
    chk("t1_rc", rc[0], 16'd1);
    peek(0, 5'd3, 8'hA5, "t1_dbg3");

    tick();
    load(1, 5'd7, 8'h3C);
    load(1, 5'd8, 8'hC3);
    read(1, 5'd7, 8'h3C, 2, "t2_rd7");
    read(1, 5'd8, 8'hC3, 2, "t2_rd8");
    chk("t2_rc", rc[1], 16'd2);
    #2;
    chk("t2_hold", rd[1], 8'hC3);

    tick();
    load(1, 5'd10, 8'h66);
    write(1, 5'd9, 8'h5A, 1, "t3_wr9");
    chk("t3_wc", wc[1], 16'd1);
    chk("t3_ea_clr", ea[1], 1'b0);
    peek(1, 5'd9, 8'h5A, "t3_dbg9");
    tick();
    a[1] = 5'd10;
    wd[1] = 8'h99;
    we[1] = 1'b1;
    tick();
    we[1] = 1'b0;
    #2;
    chk("t3_ab_rdy", rdy[1], 1'b0);
    tick();
    chk("t3_ea", ea[1], 1'b1);
    chk("t3_wc_ab", wc[1], 16'd1);
    peek(1, 5'd10, 8'h66, "t3_dbg10");

    tick();
    load(2, 5'd4, 8'h11);
    load(2, 5'd15, 8'h55);
    write(2, 5'd4, 8'hFF, 0, "t4_wr4");
    chk("t4_ew", ew[2], 1'b1);
    chk("t4_wc0", wc[2], 16'd0);
    peek(2, 5'd4, 8'h11, "t4_dbg4");
    tick();
    write(2, 5'd15, 8'hFF, 0, "t4_wr15");
    peek(2, 5'd15, 8'h55, "t4_dbg15");
    tick();
    write(2, 5'd16, 8'h42, 0, "t4_wr16");
    peek(2, 5'd16, 8'h42, "t4_dbg16");
    chk("t4_wc1", wc[2], 16'd1);
    tick();
    write(2, 5'd20, 8'h24, 0, "t4_wr20");
    peek(2, 5'd20, 8'h24, "t4_dbg20");
    chk("t4_wc2", wc[2], 16'd2);

    tick();
    oe[0] = 1'b1;
    write(0, 5'd2, 8'h77, 0, "t5_col");
    oe[0] = 1'b0;
    chk("t5_ec", ec[0], 1'b1);
    chk("t5_ea_clr", ea[0], 1'b0);
    chk("t5_wc", wc[0], 16'd1);
    chk("t5_rc", rc[0], 16'd1);
    peek(0, 5'd2, 8'h77, "t5_dbg2");
    tick();
    le[0] = 1'b1; la[0] = 5'd2; ld[0] = 8'h00;
    write(0, 5'd2, 8'h88, 0, "t5_race");
    le[0] = 1'b0;
    chk("t5_ea", ea[0], 1'b1);
    chk("t5_wc_drop", wc[0], 16'd1);
    peek(0, 5'd2, 8'h00, "t5_dbg2b");
    tick();
    le[0] = 1'b1; la[0] = 5'd6; ld[0] = 8'h34;
    write(0, 5'd5, 8'h12, 0, "t5_split");
    le[0] = 1'b0;
    chk("t5_wc2", wc[0], 16'd2);
    peek(0, 5'd5, 8'h12, "t5_dbg5");
    peek(0, 5'd6, 8'h34, "t5_dbg6");

    tick();
    load(3, 5'd12, 8'h5E);
    read(3, 5'd12, 8'h5E, 3, "t6_rd12");
    chk("t6_rc", rc[3], 16'd1);
    a[3] = 5'd12;
    oe[3] = 1'b1;
    tick();
    #2;
    chk("t6_wait_rdy", rdy[3], 1'b0);
    rst_n = 1'b0;
    #1;
    oe[3] = 1'b0;
    chk("t6_rst_rdy", rdy[3], 1'b0);
    chk("t6_rst_rdata", rd[3], 8'h00);
    chk("t6_rst_rc3", rc[3], 16'd0);
    chk("t6_rst_rc1", rc[1], 16'd0);
    chk("t6_rst_wc0", wc[0], 16'd0);
    chk("t6_rst_flags", {ec[0], ea[0], ea[1], ew[2]}, 4'b0000);
    peek(3, 5'd12, 8'h5E, "t6_mem12");
    peek(0, 5'd2, 8'h00, "t6_mem2");
    tick();
    rst_n = 1'b1;
    tick();
    read(3, 5'd12, 8'h5E, 3, "t6_post");
    chk("t6_rc_post", rc[3], 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
